// File: rtl/adc_sample_filter_pkg.sv
// Shared ADC constants for the sample filter, the ADC reader and the J1 io address map.
// Pure definitions; no latency, no flow control.
package adc_sample_filter_pkg;
  localparam int ADC_SAMPLE_WIDTH = 10;
  localparam logic [ADC_SAMPLE_WIDTH-1:0] ADC_FULL_SCALE = 10'h3FF;
endpackage

// File: rtl/adc_min_max.sv
// Running min/max of qualified samples since reset/clear; updates 1 cycle after valid.
// No backpressure: accepts a sample every cycle.
module adc_min_max
  import adc_sample_filter_pkg::*;
#(
  parameter int W = ADC_SAMPLE_WIDTH
) (
  input  logic         clk12MHz,
  input  logic         reset,
  input  logic         clear,
  input  logic [W-1:0] sample,
  input  logic         valid,
  output logic [W-1:0] min,
  output logic [W-1:0] max
);

  logic         seen_q, seen_d;
  logic [W-1:0] min_q, min_d;
  logic [W-1:0] max_q, max_d;

  // The first sample loads both bounds; afterwards only strictly new extremes move them.
  always_comb begin
    seen_d = seen_q;
    min_d  = min_q;
    max_d  = max_q;
    if (clear) begin
      seen_d = 1'b0;
      min_d  = '1;
      max_d  = '0;
    end else if (valid) begin
      seen_d = 1'b1;
      if (!seen_q || (sample < min_q)) min_d = sample;
      if (!seen_q || (sample > max_q)) max_d = sample;
    end
  end

  always_ff @(posedge clk12MHz or posedge reset) begin
    if (reset) begin
      seen_q <= 1'b0;
      min_q  <= '1;
      max_q  <= '0;
    end else begin
      seen_q <= seen_d;
      min_q  <= min_d;
      max_q  <= max_d;
    end
  end

  assign min = min_q;
  assign max = max_q;

endmodule

// File: rtl/adc_sample_filter.sv
// Boxcar mean over the last 2**LOG2_DEPTH ADC samples plus running min/max; sample_valid -> avg_valid 2 cycles.
// No backpressure: back-to-back samples accepted every cycle.
module adc_sample_filter
  import adc_sample_filter_pkg::*;
#(
  parameter int SAMPLE_WIDTH = ADC_SAMPLE_WIDTH,
  parameter int LOG2_DEPTH   = 3
) (
  input  logic                    clk12MHz,
  input  logic                    reset,
  input  logic [SAMPLE_WIDTH-1:0] sample_in,
  input  logic                    sample_valid,
  input  logic                    clear,
  output logic [SAMPLE_WIDTH-1:0] avg_out,
  output logic                    avg_valid,
  output logic [SAMPLE_WIDTH-1:0] min_out,
  output logic [SAMPLE_WIDTH-1:0] max_out,
  output logic                    filled
);

  localparam int DEPTH = 1 << LOG2_DEPTH;
  localparam int SUMW  = SAMPLE_WIDTH + LOG2_DEPTH;
  localparam logic [LOG2_DEPTH:0] FULL_CNT = (LOG2_DEPTH + 1)'(DEPTH);

  logic [SAMPLE_WIDTH-1:0] win_q [DEPTH];
  logic [LOG2_DEPTH-1:0]   wr_ptr_q, wr_ptr_d;
  logic [LOG2_DEPTH:0]     fill_q, fill_d;
  logic [SUMW-1:0]         sum_q, sum_d;
  logic                    s1_vld_q, s1_vld_d;
  logic [SAMPLE_WIDTH-1:0] avg_q, avg_d;
  logic                    avg_vld_q, avg_vld_d;
  logic                    accept;

  assign accept = sample_valid && !clear;

  // The sum is updated modulo 2**SUMW; the true value always fits, so wrap is harmless.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    fill_d    = fill_q;
    sum_d     = sum_q;
    avg_d     = avg_q;
    s1_vld_d  = accept;
    avg_vld_d = s1_vld_q && !clear;
    if (clear) begin
      wr_ptr_d = '0;
      fill_d   = '0;
      sum_d    = '0;
      avg_d    = '0;
    end else begin
      if (accept) begin
        wr_ptr_d = wr_ptr_q + LOG2_DEPTH'(1);
        sum_d    = sum_q + SUMW'(sample_in) - SUMW'(win_q[wr_ptr_q]);
        if (fill_q != FULL_CNT) fill_d = fill_q + (LOG2_DEPTH + 1)'(1);
      end
      if (s1_vld_q) avg_d = sum_q[SUMW-1:LOG2_DEPTH];
    end
  end

  always_ff @(posedge clk12MHz or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) win_q[i] <= '0;
    end else if (clear) begin
      for (int i = 0; i < DEPTH; i++) win_q[i] <= '0;
    end else if (accept) begin
      win_q[wr_ptr_q] <= sample_in;
    end
  end

  always_ff @(posedge clk12MHz or posedge reset) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      fill_q    <= '0;
      sum_q     <= '0;
      s1_vld_q  <= 1'b0;
      avg_q     <= '0;
      avg_vld_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      fill_q    <= fill_d;
      sum_q     <= sum_d;
      s1_vld_q  <= s1_vld_d;
      avg_q     <= avg_d;
      avg_vld_q <= avg_vld_d;
    end
  end

  adc_min_max #(
    .W(SAMPLE_WIDTH)
  ) u_min_max (
    .clk12MHz (clk12MHz),
    .reset    (reset),
    .clear    (clear),
    .sample   (sample_in),
    .valid    (sample_valid),
    .min      (min_out),
    .max      (max_out)
  );

  assign avg_out   = avg_q;
  assign avg_valid = avg_vld_q;
  assign filled    = (fill_q == FULL_CNT);

endmodule

// File: tb/tb_adc_sample_filter.sv
// Randomized and directed bench for adc_sample_filter against a queue-based window model.
module tb_adc_sample_filter;
  localparam int SW    = 10;
  localparam int L2    = 3;
  localparam int DEPTH = 1 << L2;
  localparam int ONES  = (1 << SW) - 1;

  logic          clk12MHz = 1'b0;
  logic          reset;
  logic [SW-1:0] sample_in;
  logic          sample_valid;
  logic          clear;
  logic [SW-1:0] avg_out;
  logic          avg_valid;
  logic [SW-1:0] min_out;
  logic [SW-1:0] max_out;
  logic          filled;

  adc_sample_filter #(
    .SAMPLE_WIDTH(SW),
    .LOG2_DEPTH  (L2)
  ) dut (
    .clk12MHz     (clk12MHz),
    .reset        (reset),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .clear        (clear),
    .avg_out      (avg_out),
    .avg_valid    (avg_valid),
    .min_out      (min_out),
    .max_out      (max_out),
    .filled       (filled)
  );

  always #5 clk12MHz = ~clk12MHz;

  int n_chk  = 0;
  int n_pass = 0;

  // Model: samples accepted since reset/clear, newest at the back.
  int hist[$];
  int m_min, m_max;
  bit m_pend;
  int m_pend_val;
  bit e_vld;
  int e_avg;
  int got_avg[$];

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  function automatic int model_mean();
    int s = 0;
    foreach (hist[i]) s += hist[i];
    return s / DEPTH;
  endfunction

  task automatic model_reset();
    hist.delete();
    m_min  = ONES;
    m_max  = 0;
    m_pend = 1'b0;
    e_vld  = 1'b0;
    e_avg  = 0;
  endtask

  task automatic check_outputs(input string ctx);
    check({ctx, ".avg_valid"}, int'(avg_valid), int'(e_vld));
    check({ctx, ".avg_out"},   int'(avg_out),   e_avg);
    check({ctx, ".min_out"},   int'(min_out),   m_min);
    check({ctx, ".max_out"},   int'(max_out),   m_max);
    check({ctx, ".filled"},    int'(filled),    int'(hist.size() == DEPTH));
  endtask

  // One clock: drive at negedge, update model at posedge, check at next negedge.
  task automatic step(input bit v, input bit c, input int s, input string ctx);
    sample_valid = v;
    clear        = c;
    sample_in    = SW'(s);
    @(posedge clk12MHz);
    if (c) begin
      model_reset();
    end else begin
      e_vld = m_pend;
      if (m_pend) e_avg = m_pend_val;
      m_pend = 1'b0;
      if (v) begin
        hist.push_back(s);
        if (hist.size() > DEPTH) void'(hist.pop_front());
        if (s < m_min) m_min = s;
        if (s > m_max) m_max = s;
        m_pend     = 1'b1;
        m_pend_val = model_mean();
      end
    end
    @(negedge clk12MHz);
    check_outputs(ctx);
    if (avg_valid) got_avg.push_back(int'(avg_out));
  endtask

  task automatic idle(input int n, input string ctx);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, ctx);
  endtask

  int ramp100[8] = '{12, 25, 37, 50, 62, 75, 87, 100};

  initial begin
    reset        = 1'b1;
    sample_valid = 1'b0;
    clear        = 1'b0;
    sample_in    = '0;
    model_reset();
    #2;
    check_outputs("reset");
    @(negedge clk12MHz);
    @(negedge clk12MHz);
    reset = 1'b0;

    // Ramp-up with back-to-back 100s
    got_avg.delete();
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, 1'b0, 100, "t1");
      if (i == DEPTH - 2) check("t1.filled_before_8th", int'(filled), 0);
    end
    check("t1.filled_on_8th", int'(filled), 1);
    idle(2, "t1");
    check("t1.count", got_avg.size(), DEPTH);
    for (int i = 0; i < DEPTH && i < got_avg.size(); i++) check("t1.avg", got_avg[i], ramp100[i]);
    check("t1.minmax", int'(min_out) * 1024 + int'(max_out), 100 * 1024 + 100);

    // Full window of 100 displaced by 500s across the pointer wrap
    got_avg.delete();
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 500, "t2");
    idle(2, "t2");
    check("t2.count", got_avg.size(), DEPTH);
    for (int i = 0; i < DEPTH && i < got_avg.size(); i++) check("t2.avg", got_avg[i], 100 + 50 * (i + 1));
    check("t2.min", int'(min_out), 100);
    check("t2.max", int'(max_out), 500);

    // Random gaps between samples must not change the averages
    step(1'b0, 1'b1, 0, "t3clr");
    got_avg.delete();
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, 1'b0, 100, "t3");
      idle($urandom_range(0, 5), "t3");
    end
    idle(2, "t3");
    check("t3.count", got_avg.size(), DEPTH);
    for (int i = 0; i < DEPTH && i < got_avg.size(); i++) check("t3.avg", got_avg[i], ramp100[i]);

    // Full-scale window, then truncation after a zero
    step(1'b0, 1'b1, 0, "t4clr");
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, ONES, "t4");
    idle(2, "t4");
    check("t4.avg_full", int'(avg_out), 'h3FF);
    step(1'b1, 1'b0, 0, "t4");
    idle(2, "t4");
    check("t4.avg_trunc", int'(avg_out), 'h37F);

    // Clear beats a simultaneous sample and kills the pending average
    step(1'b1, 1'b0, 300, "t5");
    step(1'b1, 1'b1, 700, "t5");
    check("t5.avg_valid", int'(avg_valid), 0);
    check("t5.filled", int'(filled), 0);
    check("t5.min", int'(min_out), ONES);
    idle(1, "t5");
    check("t5.no_late_pulse", int'(avg_valid), 0);
    step(1'b1, 1'b0, 40, "t5");
    idle(1, "t5");
    check("t5.avg", int'(avg_out), 5);
    check("t5.minmax", int'(min_out) * 1024 + int'(max_out), 40 * 1024 + 40);

    // Async reset between stage 1 and stage 2
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 800, "t6");
    sample_valid = 1'b0;
    #1;
    reset = 1'b1;
    #1;
    model_reset();
    check_outputs("t6.async");
    @(negedge clk12MHz);
    check_outputs("t6.held");
    reset = 1'b0;
    idle(3, "t6.after");

    // Randomized traffic with occasional clears
    for (int i = 0; i < 400; i++) begin
      int s;
      s = $urandom_range(0, 3) == 0 ? (($urandom_range(0, 1) == 1) ? ONES : 0)
                                    : int'($urandom_range(0, ONES));
      step($urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0, s, "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
